// File: rtl/rotor0_reverse_if.sv
// Handshake bundle for the rotor-0 return path.
//   in_valid/in_ready/data_in/position : letter arriving from the reflector side
//   out_valid/out_ready/data_out/out_err : decoded letter leaving toward the plugboard
// Modports: slave = the rotor stage, master = the upstream/downstream driver.
interface rotor0_reverse_if #(
  parameter int unsigned WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] position;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_err;

  modport slave (
    input  in_valid, data_in, position, out_ready,
    output in_ready, out_valid, data_out, out_err
  );

  modport master (
    output in_valid, data_in, position, out_ready,
    input  in_ready, out_valid, data_out, out_err
  );
endinterface

// File: rtl/rotor0_reverse.sv
// Rotor-0 return-path substitution: inverse wiring lookup then position unshift.
// Two registered stages with valid/ready on both sides; full throughput, 2-deep buffering.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : handshake bundle (slave side), see rotor0_reverse_if
//   letter_cnt  : count of completed output transfers (wraps)
module rotor0_reverse #(
  parameter int unsigned LETTERS = 26,
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rotor0_reverse_if.slave  bus,
  output logic [CNT_W-1:0] letter_cnt
);

  // One extra bit so inv + LETTERS cannot overflow before the modulo.
  localparam int unsigned SUM_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(LETTERS - 1);

  // Inverse rotor-0 wiring; out-of-range codes map to 0 (flagged separately).
  function automatic logic [WIDTH-1:0] inv_lookup(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    case (c)
      5'd0:  r = 5'd20;
      5'd1:  r = 5'd22;
      5'd2:  r = 5'd24;
      5'd3:  r = 5'd6;
      5'd4:  r = 5'd0;
      5'd5:  r = 5'd3;
      5'd6:  r = 5'd5;
      5'd7:  r = 5'd15;
      5'd8:  r = 5'd21;
      5'd9:  r = 5'd25;
      5'd10: r = 5'd1;
      5'd11: r = 5'd4;
      5'd12: r = 5'd2;
      5'd13: r = 5'd10;
      5'd14: r = 5'd12;
      5'd15: r = 5'd19;
      5'd16: r = 5'd7;
      5'd17: r = 5'd23;
      5'd18: r = 5'd18;
      5'd19: r = 5'd11;
      5'd20: r = 5'd17;
      5'd21: r = 5'd8;
      5'd22: r = 5'd13;
      5'd23: r = 5'd16;
      5'd24: r = 5'd14;
      5'd25: r = 5'd9;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic             s1_valid;
  logic [WIDTH-1:0] s1_inv;
  logic [WIDTH-1:0] s1_pos;
  logic             s1_err;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             out_xfer;
  logic             in_err;
  logic [SUM_W-1:0] sum_raw;
  logic [SUM_W-1:0] sum_mod;
  logic [WIDTH-1:0] dec_c;

  // Handshake control: stage 2 frees when empty or draining; stage 1 follows it.
  assign s2_free      = !bus.out_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_free;
  assign bus.in_ready = !s1_valid || s2_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_xfer     = bus.out_valid && bus.out_ready;
  assign in_err       = (bus.data_in > MAX_CODE) || (bus.position > MAX_CODE);

  // Undo the position shift: (inv + LETTERS - pos) mod LETTERS.
  always_comb begin
    sum_raw = SUM_W'(s1_inv) + SUM_W'(LETTERS) - SUM_W'(s1_pos);
    sum_mod = sum_raw;
    if (sum_raw >= SUM_W'(LETTERS)) begin
      sum_mod = sum_raw - SUM_W'(LETTERS);
    end
    dec_c = WIDTH'(sum_mod);
  end

  // Stage 1: table lookup, letter and position captured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inv   <= '0;
      s1_pos   <= '0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_inv   <= inv_lookup(bus.data_in);
      s1_pos   <= bus.position;
      s1_err   <= in_err;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.data_out  <= '0;
      bus.out_err   <= 1'b0;
    end else if (s1_adv) begin
      bus.out_valid <= 1'b1;
      bus.data_out  <= s1_err ? '0 : dec_c;
      bus.out_err   <= s1_err;
    end else if (out_xfer) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Debug count of output transfers, errored ones included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_cnt <= '0;
    end else if (out_xfer) begin
      letter_cnt <= letter_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/rotor0_reverse.md
Name: rotor0_reverse

Overview:
- Return-path (reflector-to-keyboard) substitution for rotor 0; exact inverse of the rotor-0 forward wiring at the same rotor position.
- For every letter L and position P in 0..25: reverse(forward(L,P),P) = L.
- Two-stage registered pipeline with valid/ready handshakes on both sides, so it chains directly between the reflector stage and the plugboard return stage.
- Flags out-of-range codes and keeps a debug count of processed letters.

Parameters:
- LETTERS, 26, alphabet size; all arithmetic is modulo LETTERS.
- WIDTH, 5, letter/position code width.
- CNT_W, 16, width of the processed-letter counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a letter on data_in/position.
- in_ready  out  1  block can accept this cycle.
- data_in  in  WIDTH  letter code from reflector path, A=0..Z=25.
- position  in  WIDTH  rotor-0 position for this letter, 0..25; sampled together with data_in.
- out_valid  out  1  data_out/out_err valid.
- out_ready  in  1  downstream accepts this cycle.
- data_out  out  WIDTH  decoded letter code.
- out_err  out  1  data_in or position was > 25 for this output.
- letter_cnt  out  CNT_W  number of output transfers completed.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (in_ready reads 1 once the pipe is empty), both stage valids 0, letter_cnt 0. Reset mid-operation discards in-flight letters; no output is produced for them.
- Input handshake: transfer when in_valid && in_ready. in_ready = !s1_valid || s1_advances.
- Stage 1 (on accept): register inv = INV[data_in], position, and err = (data_in > 25) || (position > 25). Position is captured with its letter; later position changes do not affect it.
- Inverse table INV[0..25] = 20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9.
- Stage 2 (s1 advances when !s2_valid || out_ready):
  - data_out = (inv + 26 - position) mod 26, computed at 6 bits, so no 5-bit overflow.
  - out_err = err; if err, data_out = 0.
- Output handshake: transfer when out_valid && out_ready. While out_valid && !out_ready, data_out and out_err hold stable.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput is 1 letter/cycle; both stages can be full, and accept-and-drain can happen in the same cycle with no bubble.
- Backpressure: with out_ready low, at most 2 letters are buffered. in_ready drops only when both stages are full and stage 2 is not draining.
- Simultaneous in/out transfer in one cycle: both happen and no data is lost or duplicated.
- letter_cnt increments by 1 on each output transfer, including errored ones, and wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset: hold rst_n low with in_valid=1 -> out_valid=0, data_out=0, letter_cnt=0. Release -> in_ready=1.
- Basic inverse, out_ready=1: (data_in=4,pos=0) -> data_out=0 two cycles later; (5,3) -> 0; (2,5) -> 19; (18,0) -> 18.
- Wrap-around: (4,25) -> 1 and (0,25) -> 21. Also sweep all 26x26 (L,P) through a forward model and check the decoded result equals L.
- Back-to-back stream with out_ready toggling 1,0,0,1,...: outputs appear in order, none dropped or duplicated, data held stable while stalled, and in_ready=0 only with 2 letters buffered.
- Illegal codes: (27,0) and (3,30) -> out_err=1, data_out=0, letter_cnt increments; the following legal letter decodes normally.
- Reset mid-stream with both stages full -> out_valid=0 immediately, letter_cnt=0; the first letter after release decodes with 2-cycle latency.
